// File: rtl/synccount_arb.sv
// synccount_arb: two-requester round-robin arbiter that time-shares a
// W-bit synchronous up-counter. The winner gets a cleared counter that
// counts 0..len, then a one-cycle done strobe. Each requester has its
// own gnt and done; the counter value is only advanced under this FSM.
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   S_IDLE | counter parked, requests sampled, round-robin arbitration
//   S_RUN  | counter advancing for the owner, gnt of owner asserted
//   S_DONE | terminal count reached, done strobe of owner asserted

module synccount_arb #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         req0_i,
    input  logic         req1_i,
    input  logic [W-1:0] len0_i,
    input  logic [W-1:0] len1_i,
    output logic         gnt0_o,
    output logic         gnt1_o,
    output logic         done0_o,
    output logic         done1_o,
    output logic         busy_o,
    output logic [W-1:0] q_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   q_q, q_d;
    logic [W-1:0]   tgt_q, tgt_d;
    // owner: 0 = requester 0, 1 = requester 1
    logic           owner_q, owner_d;
    // rr: 1 = requester 1 preferred on a tie (requester 0 served last)
    logic           rr_q, rr_d;
    logic           gnt0_q, gnt0_d;
    logic           gnt1_q, gnt1_d;
    logic           done0_q, done0_d;
    logic           done1_q, done1_d;
    logic           busy_q, busy_d;

    logic           win1;
    logic           any_req;
    logic           at_tc;

    // Requester 1 wins when alone, or on a tie when it is the preferred one.
    assign win1    = req1_i & (~req0_i | rr_q);
    assign any_req = req0_i | req1_i;
    // tgt never exceeds 2^W-1, so a full-width compare always terminates
    // before the counter could wrap.
    assign at_tc   = (q_q == tgt_q);

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        tgt_d   = tgt_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        done0_d = 1'b0;
        done1_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d = S_RUN;
                    owner_d = win1;
                    tgt_d   = win1 ? len1_i : len0_i;
                    q_d     = '0;
                    gnt0_d  = ~win1;
                    gnt1_d  = win1;
                end
            end
            S_RUN: begin
                if (at_tc) begin
                    state_d = S_DONE;
                    done0_d = ~owner_q;
                    done1_d = owner_q;
                    // The owner just finished, so the other side is preferred next.
                    rr_d    = ~owner_q;
                end else begin
                    q_d    = q_q + W'(1);
                    gnt0_d = ~owner_q;
                    gnt1_d = owner_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State, counter and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            tgt_q   <= '0;
            owner_q <= 1'b0;
            rr_q    <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            tgt_q   <= tgt_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt0_o  = gnt0_q;
    assign gnt1_o  = gnt1_q;
    assign done0_o = done0_q;
    assign done1_o = done1_q;
    assign busy_o  = busy_q;
    assign q_o     = q_q;

    // Structural invariants of the arbiter.
    a_gnt_excl : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(gnt0_q && gnt1_q));
    a_done_excl : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(done0_q && done1_q));
    a_q_bounded : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == S_RUN) |-> (q_q <= tgt_q));

endmodule
